// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the multi-port register bank and its debug dump
// engine: dump FSM state encoding and default geometry constants.
// ---------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/reg_bank_dbg_fsm.sv
// ---------------------------------------------------------------------------
// reg_bank_dbg_fsm
// Valid/ready engine that streams every register of the bank, one beat per
// accepted handshake. It owns the dump state, the beat address counter and
// the captured beat data.
//
// Ports
//   i_clock, i_reset  clock, async active-high reset
//   i_start           begin a dump (honoured only in IDLE)
//   i_ready           consumer accepts the current beat
//   o_req_addr        register whose bypassed value is wanted for capture
//   i_rd_data         bypassed value of o_req_addr, supplied by the top level
//   o_valid/o_addr/o_data  current beat
//   o_busy            dump in progress
//   o_done            one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module reg_bank_dbg_fsm
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    dbg_state_t            r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data,  w_data_nxt;

    // In IDLE the next beat is register 0; in SEND it is the successor of the
    // current beat (wraps harmlessly to 0 on the last beat). Kept outside the
    // next-state process so the data path through the top level is not seen
    // as a loop through a single process.
    assign o_req_addr = (r_state == ST_SEND) ? ADDR_WIDTH'(r_addr + 1'b1) : '0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SEND;
                    w_addr_nxt  = '0;
                    w_data_nxt  = i_rd_data;
                end
            end
            ST_SEND: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                // Data is captured at the handshake, so writes landing on a
                // stalled beat's register do not disturb that beat.
                if (i_ready) begin
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt = ST_DONE;
                        w_addr_nxt  = '0;
                        w_data_nxt  = '0;
                    end else begin
                        w_addr_nxt = ADDR_WIDTH'(r_addr + 1'b1);
                        w_data_nxt = i_rd_data;
                    end
                end
            end
            ST_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/reg_bank_mp.sv
// ---------------------------------------------------------------------------
// reg_bank_mp
// Parametrised MIPS register file: NUM_READ combinational read ports with
// write-to-read bypass, one write port, optional hardwired-zero r0 and a
// debug dump engine that streams all registers over valid/ready.
//
// Ports
//   i_clock, i_reset              clock, async active-high reset
//   i_regwrite/i_wr_addr/i_wr_data write port (WB stage)
//   i_rd_addr / o_rd_data         packed read ports, port k at slice k
//   i_dbg_start, i_dbg_ready      dump control / consumer ready
//   o_dbg_valid/addr/data         dump beat
//   o_dbg_busy, o_dbg_done        dump status
// ---------------------------------------------------------------------------
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_regwrite,
    input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] o_rd_data,
    input  logic                           i_dbg_start,
    input  logic                           i_dbg_ready,
    output logic                           o_dbg_valid,
    output logic [ADDR_WIDTH-1:0]          o_dbg_addr,
    output logic [DATA_WIDTH-1:0]          o_dbg_data,
    output logic                           o_dbg_busy,
    output logic                           o_dbg_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_regs;

    // Read port NUM_READ is the internal one used by the dump engine.
    logic [NUM_READ:0][ADDR_WIDTH-1:0] w_raddr;
    logic [NUM_READ:0][DATA_WIDTH-1:0] w_rdata;
    logic [ADDR_WIDTH-1:0]             w_dbg_req;

    logic w_wr_blocked;
    assign w_wr_blocked = (ZERO_REG != 0) && (i_wr_addr == '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_regs <= '0;
        end else if (i_regwrite && !w_wr_blocked) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_READ; k++) begin : g_port_map
            assign w_raddr[k]                        = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_rdata[k];
        end
        assign w_raddr[NUM_READ] = w_dbg_req;

        for (k = 0; k <= NUM_READ; k++) begin : g_rd
            logic w_zero, w_hit;
            assign w_zero = (ZERO_REG != 0) && (w_raddr[k] == '0);
            // Bypass is suppressed during reset so reads show cleared state.
            assign w_hit  = i_regwrite && !i_reset && (w_raddr[k] == i_wr_addr);
            assign w_rdata[k] = w_zero ? '0 :
                                w_hit  ? i_wr_data :
                                         r_regs[w_raddr[k]];
        end
    endgenerate

    reg_bank_dbg_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dbg (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (i_dbg_start),
        .i_ready    (i_dbg_ready),
        .o_req_addr (w_dbg_req),
        .i_rd_data  (w_rdata[NUM_READ]),
        .o_valid    (o_dbg_valid),
        .o_addr     (o_dbg_addr),
        .o_data     (o_dbg_data),
        .o_busy     (o_dbg_busy),
        .o_done     (o_dbg_done)
    );

endmodule
